// File: rtl/prio_enc_bcd_scan.sv
// Priority encoder with a sequential binary-to-BCD converter
// and a time-multiplexed 4511-style 7-segment decimal display.
module prio_enc_bcd_scan #(
    parameter int N_IN     = 16,
    parameter int DIGITS   = 2,
    parameter int SCAN_DIV = 1000,
    parameter int LZB      = 1,
    localparam int IDX_W   = $clog2(N_IN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ei_n,
    input  logic [N_IN-1:0]   in_n,
    input  logic              le,
    input  logic              bi_n,
    input  logic              lt_n,
    output logic [IDX_W-1:0]  code,
    output logic              gs_n,
    output logic              eo_n,
    output logic              busy,
    output logic [7:0]        seg,
    output logic [DIGITS-1:0] dig_n
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(IDX_W + 1);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int PW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    if (10 ** DIGITS < N_IN) begin : g_chk
        $error("DIGITS too small to show N_IN-1");
    end

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            hit;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] sh;
    logic [BW-1:0]   bcd;
    logic [BW-1:0]   adj;
    logic [BW-1:0]   disp;
    logic            cap_gs;
    logic [CW-1:0]   bit_cnt;
    logic [SW-1:0]   cnt;
    logic [PW-1:0]   ptr;
    logic [DIGITS-1:0] blank;
    logic [3:0]      cur;
    logic            cur_blank;
    logic [7:0]      seg_nxt;
    logic [DIGITS-1:0] dig_nxt;

    function automatic logic [6:0] dec(input logic [3:0] v);
        case (v)
            4'd0:    dec = 7'h3F;
            4'd1:    dec = 7'h06;
            4'd2:    dec = 7'h5B;
            4'd3:    dec = 7'h4F;
            4'd4:    dec = 7'h66;
            4'd5:    dec = 7'h6D;
            4'd6:    dec = 7'h7C;
            4'd7:    dec = 7'h07;
            4'd8:    dec = 7'h7F;
            4'd9:    dec = 7'h67;
            default: dec = 7'h00;
        endcase
    endfunction

    // Ascending scan so the highest low line wins.
    always_comb begin
        hit = 1'b0;
        win = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (!in_n[i]) begin
                hit = 1'b1;
                win = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            code <= '0;
            gs_n <= 1'b1;
            eo_n <= 1'b1;
        end else if (ei_n) begin
            code <= '0;
            gs_n <= 1'b1;
            eo_n <= 1'b1;
        end else if (!hit) begin
            code <= '0;
            gs_n <= 1'b1;
            eo_n <= 1'b0;
        end else begin
            code <= win;
            gs_n <= 1'b0;
            eo_n <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (!le) state_nxt = SHIFT;
            SHIFT:   if (bit_cnt == CW'(IDX_W - 1)) state_nxt = LOAD;
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        adj = bcd;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
        end
    end

    // An all-ones nibble is out of the 0-9 range and decodes dark.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh      <= '0;
            bcd     <= '0;
            cap_gs  <= 1'b1;
            bit_cnt <= '0;
            disp    <= '1;
        end else begin
            case (state)
                IDLE: if (!le) begin
                    sh      <= code;
                    bcd     <= '0;
                    cap_gs  <= gs_n;
                    bit_cnt <= '0;
                end
                SHIFT: begin
                    {bcd, sh} <= {adj, sh} << 1;
                    bit_cnt   <= bit_cnt + 1'b1;
                end
                LOAD: if (!le) disp <= cap_gs ? '1 : bcd;
                default: ;
            endcase
        end
    end

    assign busy = (state == SHIFT) || (state == LOAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            ptr <= '0;
        end else if (cnt == SW'(SCAN_DIV - 1)) begin
            cnt <= '0;
            ptr <= (ptr == PW'(DIGITS - 1)) ? '0 : ptr + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        logic zhi;
        zhi   = 1'b1;
        blank = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zhi      = zhi && (disp[4*i +: 4] == 4'd0);
            blank[i] = (LZB != 0) && zhi && (i != 0);
        end
    end

    always_comb begin
        cur       = 4'hF;
        cur_blank = 1'b1;
        dig_nxt   = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (ptr == PW'(i)) begin
                cur        = disp[4*i +: 4];
                cur_blank  = blank[i];
                dig_nxt[i] = 1'b0;
            end
        end
        seg_nxt = 8'h00;
        if (cnt == '0)     dig_nxt = '1;
        else if (!lt_n)    seg_nxt = 8'h7F;
        else if (!bi_n)    seg_nxt = 8'h00;
        else if (!cur_blank) seg_nxt = {1'b0, dec(cur)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg   <= 8'h00;
            dig_n <= '1;
        end else begin
            seg   <= seg_nxt;
            dig_n <= dig_nxt;
        end
    end

endmodule

// File: tb/tb_prio_enc_bcd_scan.sv
// Directed bench for prio_enc_bcd_scan: encoder flags, BCD display,
// latch/lamp-test/blanking controls and scan sequencing.
module tb_prio_enc_bcd_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst_b;
    logic        ei_n;
    logic [15:0] in_n;
    logic        le;
    logic        bi_n;
    logic        lt_n;
    logic [3:0]  code, code_b;
    logic        gs_n, gs_n_b;
    logic        eo_n, eo_n_b;
    logic        busy, busy_b;
    logic [7:0]  seg, seg_b;
    logic [1:0]  dig_n, dig_n_b;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    prio_enc_bcd_scan #(
        .N_IN(16), .DIGITS(2), .SCAN_DIV(8), .LZB(1)
    ) u_dut (
        .clk(clk), .rst(rst), .ei_n(ei_n), .in_n(in_n),
        .le(le), .bi_n(bi_n), .lt_n(lt_n),
        .code(code), .gs_n(gs_n), .eo_n(eo_n), .busy(busy),
        .seg(seg), .dig_n(dig_n)
    );

    prio_enc_bcd_scan #(
        .N_IN(16), .DIGITS(2), .SCAN_DIV(4), .LZB(1)
    ) u_scan (
        .clk(clk), .rst(rst_b), .ei_n(ei_n), .in_n(in_n),
        .le(le), .bi_n(bi_n), .lt_n(lt_n),
        .code(code_b), .gs_n(gs_n_b), .eo_n(eo_n_b), .busy(busy_b),
        .seg(seg_b), .dig_n(dig_n_b)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic expect_slot(input string tag, input int d,
                               input logic [6:0] exp);
        logic [1:0] want;
        logic [7:0] s;
        bit found;
        want  = ~(2'b01 << d);
        found = 1'b0;
        s     = 8'h00;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (dig_n === want) begin
                found = 1'b1;
                s     = seg;
            end
        end
        chk(tag, found ? {24'h0, s} : 32'hDEAD, {25'h0, exp});
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [1:0] scan_exp [8];

    initial begin
        scan_exp = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b01};
        rst   = 1'b1;
        rst_b = 1'b1;
        ei_n  = 1'b1;
        in_n  = 16'hFFFF;
        le    = 1'b0;
        bi_n  = 1'b1;
        lt_n  = 1'b1;
        cycles(3);
        chk("rst_code", 32'(code), 32'd0);
        chk("rst_gs",   32'(gs_n), 32'd1);
        chk("rst_eo",   32'(eo_n), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_seg",  32'(seg),  32'd0);
        chk("rst_dig",  32'(dig_n), 32'd3);

        rst  = 1'b0;
        ei_n = 1'b0;
        cycles(1);
        chk("idle_code", 32'(code), 32'd0);
        chk("idle_gs",   32'(gs_n), 32'd1);
        chk("idle_eo",   32'(eo_n), 32'd0);
        cycles(20);
        expect_slot("idle_units", 0, 7'h00);
        expect_slot("idle_tens",  1, 7'h00);

        in_n = 16'h7FF7;
        cycles(1);
        chk("p15_code", 32'(code), 32'd15);
        chk("p15_gs",   32'(gs_n), 32'd0);
        chk("p15_eo",   32'(eo_n), 32'd1);
        cycles(14);
        expect_slot("p15_units", 0, 7'h6D);
        expect_slot("p15_tens",  1, 7'h06);

        in_n = 16'hFFBF;
        cycles(1);
        chk("p6_code", 32'(code), 32'd6);
        cycles(14);
        expect_slot("p6_units", 0, 7'h7C);
        expect_slot("p6_tens",  1, 7'h00);

        le   = 1'b1;
        in_n = 16'hFDFF;
        cycles(1);
        chk("p9_code", 32'(code), 32'd9);
        cycles(20);
        expect_slot("le_hold_units", 0, 7'h7C);
        le = 1'b0;
        cycles(14);
        expect_slot("p9_units", 0, 7'h67);
        expect_slot("p9_tens",  1, 7'h00);

        in_n = 16'hFBFF;
        cycles(15);
        expect_slot("p10_units", 0, 7'h3F);
        expect_slot("p10_tens",  1, 7'h06);

        in_n = 16'hFFFE;
        cycles(1);
        chk("p0_gs", 32'(gs_n), 32'd0);
        cycles(14);
        expect_slot("p0_units", 0, 7'h3F);
        expect_slot("p0_tens",  1, 7'h00);

        ei_n = 1'b1;
        cycles(1);
        chk("dis_code", 32'(code), 32'd0);
        chk("dis_gs",   32'(gs_n), 32'd1);
        chk("dis_eo",   32'(eo_n), 32'd1);
        ei_n = 1'b0;

        lt_n = 1'b0;
        bi_n = 1'b0;
        expect_slot("lt_units", 0, 7'h7F);
        expect_slot("lt_tens",  1, 7'h7F);
        lt_n = 1'b1;
        expect_slot("bi_units", 0, 7'h00);
        expect_slot("bi_tens",  1, 7'h00);
        bi_n = 1'b1;

        chk("scan_rst_dig", 32'(dig_n_b), 32'd3);
        chk("scan_rst_busy", 32'(busy_b), 32'd0);
        rst_b = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("scan_seq%0d", k), 32'(dig_n_b), 32'(scan_exp[k]));
        end
        chk("scan_mid_busy", 32'(busy_b), 32'd1);
        rst_b = 1'b1;
        cycles(1);
        chk("scan_rr_busy", 32'(busy_b), 32'd0);
        chk("scan_rr_dig",  32'(dig_n_b), 32'd3);
        chk("scan_rr_seg",  32'(seg_b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
